// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a UART core: captures each byte the core flags as available,
// acknowledges it with a one-cycle read pulse, and buffers it for the register decoder.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [7:0]    core_data_i,
  input  logic          core_avail_i,
  output logic          core_rd_o,
  input  logic          rd_i,
  input  logic          clr_i,
  input  logic [AW:0]   thresh_i,
  output logic [7:0]    data_o,
  output logic [AW:0]   count_o,
  output logic          empty_o,
  output logic          full_o,
  output logic          overrun_o,
  output logic          irq_o
);

  typedef enum logic [1:0] {IDLE, ACK, WAIT} state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  state_t          state, state_next;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            overrun;
  logic            wr_req, wr_ok, pop;

  always_comb begin
    state_next = state;
    wr_req     = 1'b0;
    unique case (state)
      IDLE: if (core_avail_i) begin
        wr_req     = 1'b1;
        state_next = ACK;
      end
      ACK:  state_next = WAIT;
      WAIT: if (!core_avail_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A full FIFO still accepts the byte when a pop frees a slot in the same cycle.
  assign pop   = rd_i && (count != '0);
  assign wr_ok = wr_req && ((count != FULL_CNT) || pop);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      core_rd_o <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_next;
      core_rd_o <= (state_next == ACK);
      if (clr_i) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count   <= '0;
        overrun <= 1'b0;
      end else begin
        if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop)   rd_ptr <= rd_ptr + 1'b1;
        case ({wr_ok, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
        if (wr_req && !wr_ok) overrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok && !clr_i) mem[wr_ptr] <= core_data_i;
  end

  assign data_o    = mem[rd_ptr];
  assign count_o   = count;
  assign empty_o   = (count == '0);
  assign full_o    = (count == FULL_CNT);
  assign overrun_o = overrun;
  assign irq_o     = (thresh_i != '0) && (count >= thresh_i);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16).
module tb_uart_rx_fifo;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] core_data_i;
  logic       core_avail_i;
  logic       core_rd_o;
  logic       rd_i;
  logic       clr_i;
  logic [4:0] thresh_i;
  logic [7:0] data_o;
  logic [4:0] count_o;
  logic       empty_o, full_o, overrun_o, irq_o;

  int compared = 0;
  int mismatched = 0;

  uart_rx_fifo #(.DEPTH(16), .AW(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .core_data_i(core_data_i),
    .core_avail_i(core_avail_i), .core_rd_o(core_rd_o), .rd_i(rd_i),
    .clr_i(clr_i), .thresh_i(thresh_i), .data_o(data_o), .count_o(count_o),
    .empty_o(empty_o), .full_o(full_o), .overrun_o(overrun_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One full capture handshake; returns how many cycles core_rd_o was high.
  task automatic send(input logic [7:0] b, input logic with_pop, output int pulses);
    pulses = 0;
    core_data_i  = b;
    core_avail_i = 1'b1;
    rd_i         = with_pop;
    tick();
    rd_i = 1'b0;
    if (core_rd_o) pulses++;
    core_avail_i = 1'b0;
    tick();
    if (core_rd_o) pulses++;
    tick();
    if (core_rd_o) pulses++;
  endtask

  task automatic pop_one();
    rd_i = 1'b1;
    tick();
    rd_i = 1'b0;
  endtask

  initial begin
    int p;
    rst_i = 1'b0; core_data_i = '0; core_avail_i = 1'b0;
    rd_i = 1'b0; clr_i = 1'b0; thresh_i = 5'd4;
    #12;
    check("rst_count",   16'(count_o), 16'h0);
    check("rst_empty",   16'(empty_o), 16'h1);
    check("rst_full",    16'(full_o), 16'h0);
    check("rst_overrun", 16'(overrun_o), 16'h0);
    check("rst_irq",     16'(irq_o), 16'h0);
    check("rst_core_rd", 16'(core_rd_o), 16'h0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // Single byte, checking visibility right after the capture edge
    core_data_i = 8'h5A; core_avail_i = 1'b1;
    tick();
    check("single_rd_pulse", 16'(core_rd_o), 16'h1);
    check("single_count",    16'(count_o), 16'h1);
    check("single_data",     16'(data_o), 16'h5A);
    core_avail_i = 1'b0;
    tick();
    check("single_rd_drop",  16'(core_rd_o), 16'h0);
    tick();
    pop_one();
    check("single_empty",    16'(empty_o), 16'h1);

    // Pop on empty is ignored
    pop_one();
    check("empty_pop_count", 16'(count_o), 16'h0);

    // Fill 0x00..0x0F with threshold 4
    for (int i = 0; i < 16; i++) begin
      send(8'(i), 1'b0, p);
      check("fill_pulse", 16'(p), 16'h1);
      if (i == 2) check("irq_at_3", 16'(irq_o), 16'h0);
      if (i == 3) check("irq_at_4", 16'(irq_o), 16'h1);
    end
    check("fill_count", 16'(count_o), 16'd16);
    check("fill_full",  16'(full_o), 16'h1);
    thresh_i = 5'd0;
    #1;
    check("irq_thresh0", 16'(irq_o), 16'h0);

    // Overrun
    send(8'hAA, 1'b0, p);
    check("ovr_pulse",   16'(p), 16'h1);
    check("ovr_flag",    16'(overrun_o), 16'h1);
    check("ovr_count",   16'(count_o), 16'd16);
    for (int i = 0; i < 16; i++) begin
      check("order_data", 16'(data_o), 16'(i));
      pop_one();
    end
    check("drain_empty",  16'(empty_o), 16'h1);
    check("ovr_sticky",   16'(overrun_o), 16'h1);

    // Clear coinciding with a capture: byte discarded, overrun stays clear
    send(8'h01, 1'b0, p);
    send(8'h02, 1'b0, p);
    core_data_i = 8'hC3; core_avail_i = 1'b1; clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    check("clr_pulse",   16'(core_rd_o), 16'h1);
    check("clr_count",   16'(count_o), 16'h0);
    check("clr_overrun", 16'(overrun_o), 16'h0);
    core_avail_i = 1'b0;
    tick(); tick();
    check("clr_empty",   16'(empty_o), 16'h1);

    // Full with concurrent pop
    for (int i = 0; i < 16; i++) send(8'h10 + 8'(i), 1'b0, p);
    check("full2_full", 16'(full_o), 16'h1);
    send(8'h33, 1'b1, p);
    check("cpop_count",   16'(count_o), 16'd16);
    check("cpop_overrun", 16'(overrun_o), 16'h0);
    for (int i = 1; i < 16; i++) begin
      check("cpop_order", 16'(data_o), 16'h10 + 16'(i));
      pop_one();
    end
    check("cpop_last", 16'(data_o), 16'h33);
    pop_one();
    check("cpop_empty", 16'(empty_o), 16'h1);

    // Reset during ACK; held byte recaptured once after release
    core_data_i = 8'h77; core_avail_i = 1'b1;
    tick();
    check("mid_ack_rd",    16'(core_rd_o), 16'h1);
    rst_i = 1'b0;
    #1;
    check("mid_rst_rd",    16'(core_rd_o), 16'h0);
    check("mid_rst_count", 16'(count_o), 16'h0);
    #1;
    rst_i = 1'b1;
    tick();
    check("recap_rd",    16'(core_rd_o), 16'h1);
    check("recap_count", 16'(count_o), 16'h1);
    check("recap_data",  16'(data_o), 16'h77);
    core_avail_i = 1'b0;
    tick(); tick(); tick();
    check("recap_once",  16'(count_o), 16'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
